na_conf_wb_arbiter: RTL and testbench

Round-robin Wishbone arbiter sharing the network-adapter configuration slave (`na_conf_wb`) between several bus masters: the tile CPU data port and the debug processor. It holds the grant for a master's whole `cyc` period, routes slave responses back only to the owner, and synthesises a bus error when the slave does not answer within a configurable number of cycles. It sits between the tile bus masters and the single `na_conf_wb` slave port.

---
 rtl/na_conf_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_na_conf_wb_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/na_conf_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the network-adapter configuration slave.
// A master keeps the grant for its whole cyc period; slave responses are routed back
// to the owner only, and an error is synthesised if a strobed access goes unanswered.
module na_conf_wb_arbiter #(
  parameter int unsigned NMASTERS = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NMASTERS*32-1:0]   m_adr_i,
  input  logic [NMASTERS*32-1:0]   m_dat_i,
  input  logic [NMASTERS*4-1:0]    m_sel_i,
  input  logic [NMASTERS-1:0]      m_cyc_i,
  input  logic [NMASTERS-1:0]      m_stb_i,
  input  logic [NMASTERS-1:0]      m_we_i,
  output logic [NMASTERS-1:0]      m_ack_o,
  output logic [NMASTERS-1:0]      m_err_o,
  output logic [NMASTERS-1:0]      m_rty_o,
  output logic [31:0]              m_dat_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  output logic [3:0]               s_sel_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  input  logic                     s_rty_i,
  input  logic [31:0]              s_dat_i,
  output logic [NMASTERS-1:0]      grant_o,
  output logic                     timeout_o
);

  localparam int unsigned IdxW        = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic {StIdle, StOwned} state_e;

  state_e              state_q, state_d;
  logic [NMASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]     last_q, last_d;   // doubles as the owner index while owned
  logic [15:0]         cnt_q, cnt_d;

  logic owner_stb;
  logic slv_resp;
  logic tmo;

  assign owner_stb = m_stb_i[last_q];
  assign slv_resp  = s_ack_i | s_err_i | s_rty_i;
  // A slave response in the same cycle suppresses the synthesised error
  assign tmo       = (state_q == StOwned) && owner_stb && !slv_resp && (cnt_q == TimeoutLast);

  assign grant_o = grant_q;

  // State register: FSM state, one-hot grant, round-robin pointer and timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NMASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: pick the first requester after the previous owner, hold until cyc drops
  always_comb begin
    int unsigned idx;
    logic        found;
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    idx     = 0;
    found   = 1'b0;
    unique case (state_q)
      StIdle: begin
        for (int unsigned k = 1; k <= NMASTERS; k++) begin
          idx = (32'(last_q) + k) % NMASTERS;
          if (!found && m_cyc_i[IdxW'(idx)]) begin
            found                = 1'b1;
            last_d               = IdxW'(idx);
            grant_d              = '0;
            grant_d[IdxW'(idx)]  = 1'b1;
            state_d              = StOwned;
          end
        end
      end
      StOwned: begin
        if (!m_cyc_i[last_q]) begin
          state_d = StIdle;
          grant_d = '0;
        end else if (owner_stb && !slv_resp && !tmo) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: owner's request to the slave, slave response back to the owner only
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    m_dat_o   = '0;
    timeout_o = 1'b0;
    if (state_q == StOwned) begin
      s_adr_o          = m_adr_i[{last_q, 5'd0} +: 32];
      s_dat_o          = m_dat_i[{last_q, 5'd0} +: 32];
      s_sel_o          = m_sel_i[{last_q, 2'd0} +: 4];
      s_cyc_o          = m_cyc_i[last_q];
      s_stb_o          = owner_stb;
      s_we_o           = m_we_i[last_q];
      m_dat_o          = s_dat_i;
      m_ack_o[last_q]  = s_ack_i;
      m_rty_o[last_q]  = s_rty_i;
      m_err_o[last_q]  = s_err_i | tmo;
      timeout_o        = tmo;
    end
  end

endmodule

// File: tb/tb_na_conf_wb_arbiter.sv
// Bench for na_conf_wb_arbiter: randomized two-master traffic against a slave model whose
// response kind and latency are encoded in the address; a scoreboard checks every response.
module tb_na_conf_wb_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*32-1:0] m_adr_i, m_dat_i;
  logic [N*4-1:0]  m_sel_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [31:0]     m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]      s_sel_o;
  logic            s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  // Per-master bus drive
  logic        cyc_d [N];
  logic        stb_d [N];
  logic        we_d  [N];
  logic [31:0] adr_d [N];
  logic [31:0] dat_d [N];
  logic [3:0]  sel_d [N];

  always_comb begin
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    for (int i = 0; i < N; i++) begin
      m_cyc_i[i]          = cyc_d[i];
      m_stb_i[i]          = stb_d[i];
      m_we_i[i]           = we_d[i];
      m_adr_i[32*i +: 32] = adr_d[i];
      m_dat_i[32*i +: 32] = dat_d[i];
      m_sel_i[4*i +: 4]   = sel_d[i];
    end
  end

  na_conf_wb_arbiter #(.NMASTERS(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_rty_o   (m_rty_o),
    .m_dat_o   (m_dat_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .s_rty_i   (s_rty_i),
    .s_dat_i   (s_dat_i),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Expected beat outcome: kind 0 ack, 1 err, 2 rty, 3 no answer
  typedef struct {
    int          lat;
    int          kind;
    logic [31:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Slave model: adr[1:0] picks the response kind, adr[7:4] the wait before answering
  initial begin
    int wcnt;
    int lat;
    int kind;
    wcnt = 0; lat = 0; kind = 0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
    forever begin
      @(posedge clk);
      #2;
      s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
      s_dat_i = $urandom;
      if (!rst) begin
        wcnt = 0;
      end else if (s_cyc_o && s_stb_o) begin
        if (wcnt == 0) begin
          lat  = int'(s_adr_o[7:4]);
          kind = int'(s_adr_o[1:0]);
        end
        if (kind != 3 && wcnt == lat) begin
          case (kind)
            0:       s_ack_i = 1'b1;
            1:       s_err_i = 1'b1;
            default: s_rty_i = 1'b1;
          endcase
          s_dat_i = s_adr_o ^ s_dat_o ^ {23'b0, s_we_o, 4'b0, s_sel_o};
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Arbitration model plus monitor: owner tracking, routing checks, scoreboard pops
  initial begin
    int          own;
    int          mlast;
    int          wcnt;
    int          idx;
    int          act;
    int          ekind;
    logic [N-1:0] exp_grant;
    logic [N-1:0] resp;
    exp_t        e;
    own = -1; mlast = N - 1; wcnt = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        own = -1; mlast = N - 1;
      end else if (own < 0) begin
        for (int k = 1; k <= N; k++) begin
          idx = (mlast + k) % N;
          if (own < 0 && cyc_d[idx]) begin
            own = idx; mlast = idx;
          end
        end
      end else if (!cyc_d[own]) begin
        own = -1;
      end
      @(negedge clk);
      if (!rst) begin
        own = -1; mlast = N - 1; wcnt = 0;
        continue;
      end
      exp_grant = (own < 0) ? '0 : N'(1 << own);
      resp      = m_ack_o | m_err_o | m_rty_o;
      check("grant", 64'(grant_o), 64'(exp_grant));
      check("timeout_without_err", 64'(timeout_o & ~(|m_err_o)), 64'(0));
      if (own < 0) begin
        check("idle_slave_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, resp, timeout_o}),
              64'(0));
        check("idle_slave_data", {s_adr_o, s_dat_o}, 64'(0));
      end else begin
        check("owner_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}),
              64'({cyc_d[own], stb_d[own], we_d[own], sel_d[own]}));
        check("owner_data", {s_adr_o, s_dat_o}, {adr_d[own], dat_d[own]});
        check("nonowner_resp", 64'(resp & ~exp_grant), 64'(0));
        if (stb_d[own]) wcnt++;
        if (resp[own]) begin
          if ((own == 0 && q0.size() == 0) || (own == 1 && q1.size() == 0)) begin
            check("unexpected_resp", 64'(resp), 64'(0));
          end else begin
            e = (own == 0) ? q0.pop_front() : q1.pop_front();
            check("resp_onehot", 64'($countones({m_ack_o[own], m_err_o[own], m_rty_o[own]})),
                  64'(1));
            act   = m_ack_o[own] ? 0 : (m_err_o[own] ? (timeout_o ? 3 : 1) : 2);
            ekind = (e.kind == 3 || e.lat > TO - 1) ? 3 : e.kind;
            check("resp_kind", 64'(act), 64'(ekind));
            check("resp_cycle", 64'(wcnt), 64'((ekind == 3) ? TO : e.lat + 1));
            if (ekind == 0) check("read_data", 64'(m_dat_o), 64'(e.rdata));
          end
          wcnt = 0;
        end else if (!stb_d[own]) begin
          wcnt = 0;
        end
      end
    end
  end

  // One cyc period of nbeats strobes; a one-cycle strobe gap separates beats
  task automatic run_burst(input int m, input int nbeats, input bit fixed,
                           input logic [31:0] fadr, input logic [31:0] fdat,
                           input logic fwe, input logic [3:0] fsel);
    exp_t e;
    logic got;
    int   lsel;
    logic [3:0] lat;
    @(posedge clk);
    #1;
    cyc_d[m] = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0) begin
        @(posedge clk);
        #1;
      end
      if (fixed) begin
        adr_d[m] = fadr; dat_d[m] = fdat; we_d[m] = fwe; sel_d[m] = fsel;
      end else begin
        lsel = $urandom_range(0, 9);
        case (lsel)
          6:       lat = 4'd7;
          7:       lat = 4'd6;
          8:       lat = 4'd8;
          9:       lat = 4'd10;
          default: lat = 4'($urandom_range(0, 3));
        endcase
        adr_d[m]      = $urandom;
        adr_d[m][7:4] = lat;
        adr_d[m][1:0] = 2'($urandom_range(0, 3));
        dat_d[m]      = $urandom;
        we_d[m]       = 1'($urandom_range(0, 1));
        sel_d[m]      = 4'($urandom_range(0, 15));
      end
      stb_d[m] = 1'b1;
      e.lat   = int'(adr_d[m][7:4]);
      e.kind  = int'(adr_d[m][1:0]);
      e.rdata = adr_d[m] ^ dat_d[m] ^ {23'b0, we_d[m], 4'b0, sel_d[m]};
      if (m == 0) q0.push_back(e);
      else        q1.push_back(e);
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge clk);
        got = m_ack_o[m] | m_err_o[m] | m_rty_o[m];
      end
      check("beat_done", 64'(got), 64'(1));
      @(posedge clk);
      #1;
      stb_d[m] = 1'b0;
    end
    cyc_d[m] = 1'b0;
  endtask

  task automatic random_master(input int m, input int nbursts);
    for (int i = 0; i < nbursts; i++) begin
      run_burst(m, $urandom_range(1, 3), 1'b0, '0, '0, 1'b0, '0);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      cyc_d[i] = 1'b0; stb_d[i] = 1'b0; we_d[i] = 1'b0;
      adr_d[i] = '0;   dat_d[i] = '0;   sel_d[i] = '0;
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cyc_d[0] = 1'b1;
    stb_d[0] = 1'b1;
    adr_d[0] = 32'h1234_5670;
    repeat (3) @(negedge clk);
    // Reset state with a request pending
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_slave_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 64'(0));
    check("rst_slave_data", {s_adr_o, s_dat_o}, 64'(0));
    check("rst_resp", 64'({m_ack_o, m_err_o, m_rty_o, timeout_o, m_dat_o}), 64'(0));
    cyc_d[0] = 1'b0; stb_d[0] = 1'b0; adr_d[0] = '0;
    rst = 1'b1;

    // Single write from master 0, ack two cycles after the strobe is raised
    run_burst(0, 1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF);
    repeat (2) @(posedge clk);

    // Both masters, four single transfers each, issued together
    fork
      begin repeat (4) run_burst(0, 1, 1'b0, '0, '0, 1'b0, '0); end
      begin repeat (4) run_burst(1, 1, 1'b0, '0, '0, 1'b0, '0); end
    join
    repeat (2) @(posedge clk);

    // Master 1 read burst while master 0 requests
    fork
      run_burst(1, 3, 1'b1, 32'h0000_1120, 32'h0, 1'b0, 4'hF);
      begin repeat (2) @(posedge clk); run_burst(0, 1, 1'b1, 32'h0000_2200, '0, 1'b0, 4'h3); end
    join
    repeat (2) @(posedge clk);

    // Timeout, answer on the last allowed cycle, late answer, err and rty routing
    run_burst(0, 1, 1'b1, 32'h0000_0003, 32'h1, 1'b1, 4'h1);
    run_burst(0, 1, 1'b1, 32'h0000_0070, 32'h2, 1'b0, 4'h2);
    run_burst(1, 1, 1'b1, 32'h0000_0080, 32'h3, 1'b1, 4'h4);
    run_burst(1, 2, 1'b1, 32'h0000_0021, 32'h4, 1'b1, 4'h8);
    run_burst(0, 1, 1'b1, 32'h0000_0032, 32'h5, 1'b0, 4'hC);
    run_burst(1, 1, 1'b1, 32'h0000_0012, 32'h6, 1'b0, 4'hA);
    repeat (2) @(posedge clk);

    // Randomized concurrent traffic
    fork
      random_master(0, 12);
      random_master(1, 12);
    join
    repeat (3) @(posedge clk);

    // Reset in the middle of an unanswered access from master 1
    @(posedge clk);
    #1;
    cyc_d[1] = 1'b1; stb_d[1] = 1'b1; adr_d[1] = 32'hCAFE_0003; dat_d[1] = 32'h55AA_55AA;
    we_d[1] = 1'b1; sel_d[1] = 4'hF;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_grant", 64'(grant_o), 64'(2'b10));
    rst = 1'b0;
    #1;
    check("midrst_grant", 64'(grant_o), 64'(0));
    check("midrst_slave_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 64'(0));
    check("midrst_slave_data", {s_adr_o, s_dat_o}, 64'(0));
    check("midrst_resp", 64'({m_ack_o, m_err_o, m_rty_o, timeout_o}), 64'(0));
    stb_d[1] = 1'b0; adr_d[1] = '0; dat_d[1] = '0; we_d[1] = 1'b0; sel_d[1] = '0;
    cyc_d[0] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_first_grant", 64'(grant_o), 64'(2'b01));
    cyc_d[0] = 1'b0; cyc_d[1] = 1'b0;
    repeat (3) @(posedge clk);

    check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
